universal_shift_register: RTL and testbench

//  Parametrised successor to the 8-bit load/shift register. Adds any width, left/right shift,

---
 rtl/spu_pkg.sv | 22 ++
 rtl/shift_step_comb.sv | 54 +++++
 rtl/universal_shift_register.sv | 150 +++++++++++++++
 tb/tb_universal_shift_register.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// ----------------------------------------------------------------------------
// spu_pkg
//   Shared SPU shifter definitions.
//   - shift_mode_e : fill rule applied to the vacated bit position
//   - shift_dir_e  : shift direction (left = toward MSB, right = toward LSB)
//   The SHM_* and DIR_* names are used by the step function and by the top.
// ----------------------------------------------------------------------------
package spu_pkg;

    typedef enum logic [1:0] {
        SHM_SERIAL = 2'b00,   // fill from serial_in
        SHM_ROTATE = 2'b01,   // fill with the bit leaving the other end
        SHM_ARITH  = 2'b10,   // right: replicate sign bit; left: zero fill
        SHM_ZERO   = 2'b11    // fill with zero
    } shift_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

endpackage : spu_pkg

// File: rtl/shift_step_comb.sv
// ----------------------------------------------------------------------------
// shift_step_comb
//   Pure combinational single-step shifter. Given the current register value,
//   a direction, a fill mode and the serial input, produces the value after
//   exactly one shift. Used by both the manual and the burst paths of
//   universal_shift_register so the two paths cannot diverge.
//
//   Ports
//     q_i          in   WIDTH  current register value
//     dir_i        in   1      0 = left (toward MSB), 1 = right (toward LSB)
//     mode_i       in   2      fill mode (see spu_pkg::shift_mode_e)
//     serial_in_i  in   1      fill bit used in SHM_SERIAL
//     q_next_o     out  WIDTH  value after one shift
// ----------------------------------------------------------------------------
module shift_step_comb
    import spu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_next_o
);

    logic fill;

    always_comb begin
        fill     = 1'b0;
        q_next_o = q_i;
        if (shift_dir_e'(dir_i) == DIR_LEFT) begin
            // Arithmetic left is logical left: the vacated LSB takes zero.
            case (shift_mode_e'(mode_i))
                SHM_SERIAL: fill = serial_in_i;
                SHM_ROTATE: fill = q_i[WIDTH-1];
                SHM_ARITH:  fill = 1'b0;
                SHM_ZERO:   fill = 1'b0;
                default:    fill = 1'b0;
            endcase
            q_next_o = {q_i[WIDTH-2:0], fill};
        end else begin
            case (shift_mode_e'(mode_i))
                SHM_SERIAL: fill = serial_in_i;
                SHM_ROTATE: fill = q_i[0];
                SHM_ARITH:  fill = q_i[WIDTH-1];   // sign extension
                SHM_ZERO:   fill = 1'b0;
                default:    fill = 1'b0;
            endcase
            q_next_o = {fill, q_i[WIDTH-1:1]};
        end
    end

endmodule : shift_step_comb

// File: rtl/universal_shift_register.sv
// ----------------------------------------------------------------------------
// universal_shift_register
//   Parametrised load/shift register with left/right shifting, four fill
//   modes, a serial output and an auto-run burst engine that performs
//   'count' shifts after a single start pulse.
//
//   Ports
//     clk          in   1      rising-edge clock
//     rst          in   1      synchronous active-high reset
//     load_en      in   1      parallel load (also aborts a running burst)
//     shift_en     in   1      one manual shift (ignored while busy)
//     dir          in   1      0 = left, 1 = right
//     mode         in   2      fill mode (spu_pkg::shift_mode_e)
//     serial_in    in   1      fill bit for serial mode (sampled live in bursts)
//     parallel_in  in   WIDTH  load data
//     start        in   1      begin a burst (ignored while busy)
//     count        in   CNT_W  burst length, sampled with start
//     q            out  WIDTH  register contents
//     serial_out   out  1      bit that the next shift pushes out
//     busy         out  1      burst in progress (the burst engine state)
//     done         out  1      one-cycle pulse after the last burst shift
//
//   Control: start is a request accepted only when busy is low; busy then
//   stays high for exactly 'count' cycles, one shift per cycle. A start with
//   count == 0 is accepted and completes immediately (done, no busy).
//   Priority on each edge: rst > load_en > start > burst step > shift_en.
// ----------------------------------------------------------------------------
module universal_shift_register
    import spu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] q_q,        q_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [CNT_W-1:0] rem_q,      rem_d;
    logic             cap_dir_q,  cap_dir_d;
    logic [1:0]       cap_mode_q, cap_mode_d;

    // ------------------------------------------------------------------------
    // Shift datapath: a burst uses the direction/mode captured at start,
    // otherwise the live inputs. serial_in is always live.
    // ------------------------------------------------------------------------
    logic             eff_dir;
    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] q_shifted;

    assign eff_dir  = busy_q ? cap_dir_q  : dir;
    assign eff_mode = busy_q ? cap_mode_q : mode;

    shift_step_comb #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i         (q_q),
        .dir_i       (eff_dir),
        .mode_i      (eff_mode),
        .serial_in_i (serial_in),
        .q_next_o    (q_shifted)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        q_d        = q_q;
        busy_d     = busy_q;
        done_d     = 1'b0;          // done is a single-cycle pulse
        rem_d      = rem_q;
        cap_dir_d  = cap_dir_q;
        cap_mode_d = cap_mode_q;

        if (load_en) begin
            // Load always wins and silently aborts any burst.
            q_d    = parallel_in;
            busy_d = 1'b0;
            rem_d  = '0;
        end else if (start && !busy_q) begin
            // Start edge only captures; the first shift happens next edge.
            cap_dir_d  = dir;
            cap_mode_d = mode;
            if (count != '0) begin
                busy_d = 1'b1;
                rem_d  = count;
            end else begin
                done_d = 1'b1;
            end
        end else if (busy_q) begin
            q_d = q_shifted;
            if (rem_q != '0) begin
                rem_d = rem_q - CNT_W'(1);
            end
            if (rem_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (shift_en) begin
            q_d = q_shifted;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rem_q      <= '0;
            cap_dir_q  <= 1'b0;
            cap_mode_q <= 2'b00;
        end else begin
            q_q        <= q_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rem_q      <= rem_d;
            cap_dir_q  <= cap_dir_d;
            cap_mode_q <= cap_mode_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign q          = q_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign serial_out = (shift_dir_e'(eff_dir) == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic             clk;
    logic             rst;
    logic             load_en;
    logic             shift_en;
    logic             dir;
    logic [1:0]       mode;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .shift_en    (shift_en),
        .dir         (dir),
        .mode        (mode),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .start       (start),
        .count       (count),
        .q           (q),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done)
    );

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model: a register value, a burst-shifts-left
    // counter and a pending-done flag, updated from the input rules.
    // ------------------------------------------------------------------------
    logic [7:0] m_q;
    logic       m_busy;
    logic       m_done;
    int         m_left;
    logic       m_cap_dir;
    logic [1:0] m_cap_mode;

    function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic d,
                                             input logic [1:0] m, input logic si);
        int fill;
        int r;
        if (d == 1'b0) begin
            fill = (m == 2'd0) ? int'(si) : (m == 2'd1) ? int'(v[7]) : 0;
            r = ((int'(v) * 2) + fill) % 256;
        end else begin
            fill = (m == 2'd0) ? int'(si) : (m == 2'd1) ? int'(v[0]) :
                   (m == 2'd2) ? int'(v[7]) : 0;
            r = (int'(v) / 2) + fill * 128;
        end
        return 8'(r);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q = 0; m_busy = 0; m_done = 0; m_left = 0; m_cap_dir = 0; m_cap_mode = 0;
        end else begin
            m_done = 1'b0;
            if (load_en) begin
                m_q = parallel_in; m_busy = 0; m_left = 0;
            end else if (start && !m_busy) begin
                m_cap_dir = dir; m_cap_mode = mode;
                m_left = int'(count);
                m_busy = (m_left > 0);
                m_done = (m_left == 0);
            end else if (m_busy) begin
                m_q = ref_shift(m_q, m_cap_dir, m_cap_mode, serial_in);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end else if (shift_en) begin
                m_q = ref_shift(m_q, dir, mode, serial_in);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helper
    // ------------------------------------------------------------------------
    task automatic do_load(input logic [7:0] v);
        load_en = 1'b1; parallel_in = v;
        tick();
        load_en = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; load_en = 1'b1; parallel_in = 8'hFF;
        tick();
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h exp 00", q); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        rst = 1'b0; load_en = 1'b0; parallel_in = '0;
    endtask

    task automatic test_serial_left();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] e;
        exp_q = '{8'h55, 8'hAB, 8'h57, 8'hAF, 8'h5F};
        do_load(8'hAA);
        checks++;
        if (q !== 8'hAA) begin errors++; $display("FAIL load_aa: got %h exp aa", q); end
        shift_en = 1'b1; dir = 1'b0; mode = 2'b00; serial_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL serial_left[%0d]: got %h exp %h", i, q, e); end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_arith_right();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] e;
        exp_q = '{8'hC8, 8'hE4, 8'hF2};
        do_load(8'h90);
        dir = 1'b1; mode = 2'b10;
        #1;
        checks++;
        if (serial_out !== 1'b0) begin errors++; $display("FAIL arith_sout: got %b exp 0", serial_out); end
        shift_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL arith_right[%0d]: got %h exp %h", i, q, e); end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_burst_rotate();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] e;
        int busy_cycles;
        int done_pulses;
        exp_q = '{8'hC0, 8'h60, 8'h30, 8'h18};
        busy_cycles = 0;
        done_pulses = 0;
        do_load(8'h81);
        dir = 1'b1; mode = 2'b01; count = 4'd4; start = 1'b1; shift_en = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_start: got q=%h busy=%b done=%b exp q=81 busy=1 done=0", q, busy, done);
        end
        if (busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL burst_rot[%0d]: got %h exp %h", i, q, e); end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_pulses++;
            if (i == 0) begin
                // Live dir flips to left; serial_out must keep following the captured right.
                dir = 1'b0; mode = 2'b00;
                #1;
                checks++;
                if (serial_out !== 1'b0) begin errors++; $display("FAIL burst_sout: got %b exp 0", serial_out); end
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL burst_done_edge: got %b exp 1", done); end
        shift_en = 1'b0;
        tick();
        if (done === 1'b1) done_pulses++;
        checks++;
        if (busy_cycles != 4) begin errors++; $display("FAIL burst_busy_len: got %0d exp 4", busy_cycles); end
        checks++;
        if (done_pulses != 1) begin errors++; $display("FAIL burst_done_count: got %0d exp 1", done_pulses); end
        checks++;
        if (q !== 8'h18) begin errors++; $display("FAIL burst_hold: got %h exp 18", q); end
    endtask

    task automatic test_burst_zero();
        count = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h18) begin
            errors++;
            $display("FAIL zero_start: got done=%b busy=%b q=%h exp 1 0 18", done, busy, q);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h18) begin
            errors++;
            $display("FAIL zero_after: got done=%b busy=%b q=%h exp 0 0 18", done, busy, q);
        end
    endtask

    task automatic test_abort_and_load_priority();
        int done_seen;
        done_seen = 0;
        do_load(8'h0F);
        dir = 1'b0; mode = 2'b11; count = 4'd8; start = 1'b1;
        tick();                       // busy cycle 1
        start = 1'b0;
        tick();                       // busy cycle 2
        tick();                       // busy cycle 3
        checks++;
        if (busy !== 1'b1 || q !== 8'h3C) begin
            errors++;
            $display("FAIL abort_pre: got busy=%b q=%h exp 1 3c", busy, q);
        end
        load_en = 1'b1; parallel_in = 8'h3C;
        tick();
        load_en = 1'b0;
        checks++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: got q=%h busy=%b done=%b exp 3c 0 0", q, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1 || q !== 8'h3C) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles exp 0", done_seen); end
        load_en = 1'b1; shift_en = 1'b1; parallel_in = 8'hA5; dir = 1'b1; mode = 2'b11;
        tick();
        load_en = 1'b0; shift_en = 1'b0;
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL load_vs_shift: got %h exp a5", q); end
    endtask

    task automatic test_random();
        logic exp_sout;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            load_en     = ($urandom_range(0, 9) == 0);
            start       = ($urandom_range(0, 7) == 0);
            shift_en    = $urandom_range(0, 1) == 1;
            dir         = $urandom_range(0, 1) == 1;
            mode        = 2'($urandom_range(0, 3));
            serial_in   = $urandom_range(0, 1) == 1;
            parallel_in = 8'($urandom_range(0, 255));
            count       = 4'($urandom_range(0, 15));
            tick();
            // New dir/mode after the edge exercises the captured-vs-live serial_out path.
            dir = $urandom_range(0, 1) == 1;
            #1;
            exp_sout = (m_busy ? m_cap_dir : dir) ? m_q[0] : m_q[7];
            checks++;
            if (q !== m_q || busy !== m_busy || done !== m_done || serial_out !== exp_sout) begin
                errors++;
                $display("FAIL random[%0d]: got q=%h busy=%b done=%b sout=%b exp q=%h busy=%b done=%b sout=%b",
                         i, q, busy, done, serial_out, m_q, m_busy, m_done, exp_sout);
            end
        end
        rst = 1'b0; load_en = 1'b0; start = 1'b0; shift_en = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Sequence + report
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; load_en = 1'b0; shift_en = 1'b0; dir = 1'b0; mode = 2'b00;
        serial_in = 1'b0; parallel_in = '0; start = 1'b0; count = '0;
        test_reset();
        test_serial_left();
        test_arith_right();
        test_burst_rotate();
        test_burst_zero();
        test_abort_and_load_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_universal_shift_register
